pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_fwd_unit.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: divider latency,
// FSM state encoding, forwarding-select encoding and a stage-match helper.
package pipe_ctrl_pkg;

  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 5;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXE = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // A later stage can supply an operand only if it really writes a non-zero register.
  function automatic logic stage_match(input logic we, input logic [4:0] waddr,
                                       input logic [4:0] src);
    return we && (waddr != 5'd0) && (waddr == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one source register: youngest producer wins.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       exe_rf_we,
  input  logic [4:0] exe_rf_waddr,
  input  logic       mem_rf_we,
  input  logic [4:0] mem_rf_waddr,
  input  logic       wb_rf_we,
  input  logic [4:0] wb_rf_waddr,
  output logic [1:0] sel
);

  // Priority EXE > MEM > WB > register file; register 0 never matches.
  always_comb begin
    sel = FWD_RF;
    if (stage_match(exe_rf_we, exe_rf_waddr, src))
      sel = FWD_EXE;
    else if (stage_match(mem_rf_we, mem_rf_waddr, src))
      sel = FWD_MEM;
    else if (stage_match(wb_rf_we, wb_rf_waddr, src))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and divider-busy stalls, divider
// sequencing FSM, per-operand forwarding selects and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_uses_mdu,
  input  logic        exe_rf_we,
  input  logic        exe_isLW,
  input  logic        exe_is_div,
  input  logic [4:0]  exe_rf_waddr,
  input  logic [4:0]  mem_rf_waddr,
  input  logic [4:0]  wb_rf_waddr,
  input  logic        mem_rf_we,
  input  logic        wb_rf_we,
  output logic        pc_we,
  output logic        ii_we,
  output logic        ie_we,
  output logic        ie_bubble,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [31:0] stall_cnt
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             mdu_haz;
  logic             stall;

  assign mdu_busy = (state == DIV_WAIT);

  // Hazard detection and pipeline register enables; both hazards collapse into one stall.
  always_comb begin
    load_use  = exe_isLW && exe_rf_we && (exe_rf_waddr != 5'd0) &&
                ((id_use_rs && (id_rs == exe_rf_waddr)) ||
                 (id_use_rt && (id_rt == exe_rf_waddr)));
    mdu_haz   = mdu_busy && id_uses_mdu;
    stall     = load_use || mdu_haz;
    pc_we     = !stall;
    ii_we     = !stall;
    ie_we     = 1'b1;
    ie_bubble = stall;
  end

  // Divider FSM next state: start pulse only from RUN, DIV_WAIT spans DIV_LAT cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdu_start = 1'b0;
    case (state)
      RUN: begin
        if (exe_is_div) begin
          mdu_start = !reset;
          state_nxt = DIV_WAIT;
          cnt_nxt   = CNT_W'(DIV_LAT - 1);
        end
      end
      DIV_WAIT: begin
        if (cnt == '0)
          state_nxt = RUN;
        else
          cnt_nxt = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Divider FSM state register; reset abandons any divide in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stall-cycle counter, free-running wrap at 2^32.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end

  pipe_fwd_unit u_fwd_rs (
    .src          (id_rs),
    .exe_rf_we    (exe_rf_we),
    .exe_rf_waddr (exe_rf_waddr),
    .mem_rf_we    (mem_rf_we),
    .mem_rf_waddr (mem_rf_waddr),
    .wb_rf_we     (wb_rf_we),
    .wb_rf_waddr  (wb_rf_waddr),
    .sel          (fwd_rs_sel)
  );

  pipe_fwd_unit u_fwd_rt (
    .src          (id_rt),
    .exe_rf_we    (exe_rf_we),
    .exe_rf_waddr (exe_rf_waddr),
    .mem_rf_we    (mem_rf_we),
    .mem_rf_waddr (mem_rf_waddr),
    .wb_rf_we     (wb_rf_we),
    .wb_rf_waddr  (wb_rf_waddr),
    .sel          (fwd_rt_sel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use stall, forwarding priority,
// divider sequencing, reset during a divide and coincident hazards.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt, id_uses_mdu;
  logic        exe_rf_we, exe_isLW, exe_is_div;
  logic [4:0]  exe_rf_waddr, mem_rf_waddr, wb_rf_waddr;
  logic        mem_rf_we, wb_rf_we;
  logic        pc_we, ii_we, ie_we, ie_bubble, mdu_start, mdu_busy;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_uses_mdu  (id_uses_mdu),
    .exe_rf_we    (exe_rf_we),
    .exe_isLW     (exe_isLW),
    .exe_is_div   (exe_is_div),
    .exe_rf_waddr (exe_rf_waddr),
    .mem_rf_waddr (mem_rf_waddr),
    .wb_rf_waddr  (wb_rf_waddr),
    .mem_rf_we    (mem_rf_we),
    .wb_rf_we     (wb_rf_we),
    .pc_we        (pc_we),
    .ii_we        (ii_we),
    .ie_we        (ie_we),
    .ie_bubble    (ie_bubble),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_uses_mdu = 1'b0;
    exe_rf_we = 1'b0; exe_isLW = 1'b0; exe_is_div = 1'b0; exe_rf_waddr = 5'd0;
    mem_rf_we = 1'b0; mem_rf_waddr = 5'd0; wb_rf_we = 1'b0; wb_rf_waddr = 5'd0;
  endtask

  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, "_pc_we"},     32'(pc_we),     32'(!exp_stall));
    chk({tag, "_ii_we"},     32'(ii_we),     32'(!exp_stall));
    chk({tag, "_ie_we"},     32'(ie_we),     32'd1);
    chk({tag, "_ie_bubble"}, 32'(ie_bubble), 32'(exp_stall));
  endtask

  initial begin
    int stalls_seen;
    int busy_seen;
    int starts_seen;

    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_busy",      32'(mdu_busy),   32'd0);
    chk("rst_start",     32'(mdu_start),  32'd0);
    chk("rst_stall_cnt", stall_cnt,       32'd0);
    chk("rst_fwd_rs",    32'(fwd_rs_sel), 32'd0);
    chk("rst_fwd_rt",    32'(fwd_rt_sel), 32'd0);
    chk_stall("rst", 1'b0);
    reset = 1'b0;
    tick();

    // LW $2 in EXE, add $3,$2,$4 in ID: one stall, EXE select still reported.
    exe_isLW = 1'b1; exe_rf_we = 1'b1; exe_rf_waddr = 5'd2;
    id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1'b1; id_use_rt = 1'b1;
    #1;
    chk_stall("lu", 1'b1);
    chk("lu_fwd_rs_exe", 32'(fwd_rs_sel), 32'd1);
    chk("lu_fwd_rt_rf",  32'(fwd_rt_sel), 32'd0);
    tick();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    // Load now in MEM, bubble in EXE: add issues with MEM forwarding.
    exe_isLW = 1'b0; exe_rf_we = 1'b0; exe_rf_waddr = 5'd0;
    mem_rf_we = 1'b1; mem_rf_waddr = 5'd2;
    #1;
    chk_stall("lu_next", 1'b0);
    chk("lu_next_fwd_rs", 32'(fwd_rs_sel), 32'd2);
    chk("lu_next_fwd_rt", 32'(fwd_rt_sel), 32'd0);
    tick();
    chk("lu_next_stall_cnt", stall_cnt, 32'd1);

    // Load writing a register ID does not read: no stall.
    clear_inputs();
    exe_isLW = 1'b1; exe_rf_we = 1'b1; exe_rf_waddr = 5'd9;
    id_rs = 5'd9; id_use_rs = 1'b0; id_rt = 5'd3; id_use_rt = 1'b1;
    #1;
    chk("lu_unused_pc_we", 32'(pc_we), 32'd1);
    // Load to $0 never stalls and $0 never forwards.
    exe_rf_waddr = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    mem_rf_we = 1'b1; wb_rf_we = 1'b1;
    #1;
    chk("lu_r0_pc_we",  32'(pc_we),      32'd1);
    chk("r0_fwd_rs",    32'(fwd_rs_sel), 32'd0);

    // All stages write $8, ID reads $8 twice: EXE wins, then MEM, then WB.
    clear_inputs();
    exe_rf_we = 1'b1; mem_rf_we = 1'b1; wb_rf_we = 1'b1;
    exe_rf_waddr = 5'd8; mem_rf_waddr = 5'd8; wb_rf_waddr = 5'd8;
    id_rs = 5'd8; id_rt = 5'd8; id_use_rs = 1'b1; id_use_rt = 1'b1;
    #1;
    chk("fwd_all_rs", 32'(fwd_rs_sel), 32'd1);
    chk("fwd_all_rt", 32'(fwd_rt_sel), 32'd1);
    exe_rf_waddr = 5'd0;
    #1;
    chk("fwd_mem_rs", 32'(fwd_rs_sel), 32'd2);
    chk("fwd_mem_rt", 32'(fwd_rt_sel), 32'd2);
    mem_rf_we = 1'b0;
    #1;
    chk("fwd_wb_rs", 32'(fwd_rs_sel), 32'd3);
    chk("fwd_wb_rt", 32'(fwd_rt_sel), 32'd3);
    wb_rf_we = 1'b0;
    #1;
    chk("fwd_none_rs", 32'(fwd_rs_sel), 32'd0);
    tick();

    // div in EXE: start pulse, 32 busy cycles, mflo stalls throughout and issues after.
    clear_inputs();
    exe_is_div = 1'b1;
    #1;
    chk("div_start",      32'(mdu_start), 32'd1);
    chk("div_busy_pre",   32'(mdu_busy),  32'd0);
    chk("div_no_stall",   32'(pc_we),     32'd1);
    tick();
    id_uses_mdu = 1'b1;
    stalls_seen = 0; busy_seen = 0; starts_seen = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!pc_we && ie_bubble) stalls_seen++;
      if (mdu_busy) busy_seen++;
      if (mdu_start) starts_seen++;
      tick();
    end
    exe_is_div = 1'b0;
    #1;
    chk("div_stalls",      32'(stalls_seen), 32'd32);
    chk("div_busy_cycles", 32'(busy_seen),   32'd32);
    chk("div_no_restart",  32'(starts_seen), 32'd0);
    chk("div_done_busy",   32'(mdu_busy),    32'd0);
    chk_stall("mflo_issue", 1'b0);
    chk("div_stall_cnt",   stall_cnt,        32'd33);
    tick();

    // Second divide: non-MDU op passes, then coincident hazards, then reset at cnt=10.
    clear_inputs();
    exe_is_div = 1'b1;
    #1;
    chk("div2_start", 32'(mdu_start), 32'd1);
    tick();
    exe_is_div = 1'b0;
    id_rs = 5'd6; id_rt = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b1;
    #1;
    chk("busy_add_busy", 32'(mdu_busy), 32'd1);
    chk_stall("busy_add", 1'b0);
    tick();
    chk("busy_add_stall_cnt", stall_cnt, 32'd33);
    id_uses_mdu = 1'b1;
    exe_isLW = 1'b1; exe_rf_we = 1'b1; exe_rf_waddr = 5'd6;
    #1;
    chk_stall("both_haz", 1'b1);
    tick();
    chk("both_haz_cnt1", stall_cnt, 32'd34);
    tick();
    chk("both_haz_cnt2", stall_cnt, 32'd35);
    clear_inputs();
    repeat (18) tick();
    // cnt is now 10; hold a div in EXE across reset, which must not pulse start.
    chk("pre_rst_busy", 32'(mdu_busy), 32'd1);
    reset = 1'b1;
    exe_is_div = 1'b1;
    #1;
    chk("rst_start_gate", 32'(mdu_start), 32'd0);
    tick();
    chk("div_rst_busy",      32'(mdu_busy), 32'd0);
    chk("div_rst_stall_cnt", stall_cnt,     32'd0);
    reset = 1'b0;
    exe_is_div = 1'b0;
    tick();
    chk("div_rst_stays_run", 32'(mdu_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
